// File: rtl/counted_fifo_pkg.sv
// Shared defaults and operation encoding for the counted depth-search work-list FIFOs.
package counted_fifo_pkg;

    localparam int DEFAULT_DATA_SIZE_END = 63;
    localparam int DEFAULT_DEPTH_BITS    = 3;

    // Encoding is {accepted insert, accepted pop}, so the two enables cast straight to it.
    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

endpackage

// File: rtl/fifo_storage.sv
// Entry array for counted_fifo: one synchronous write port and one asynchronous read port.
module fifo_storage #(
    parameter int DATA_SIZE_END = 63,
    parameter int DEPTH_BITS    = 3
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [DEPTH_BITS-1:0]   waddr,
    input  logic [DATA_SIZE_END:0]  wdata,
    input  logic [DEPTH_BITS-1:0]   raddr,
    output logic [DATA_SIZE_END:0]  rdata
);

    logic [DATA_SIZE_END:0] mem [2**DEPTH_BITS];

    // No reset on the array: an entry is only ever observed after it has been written.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/counted_fifo.sv
// Show-ahead single-clock FIFO with occupancy count, almost levels, flush and sticky error flags.
module counted_fifo
    import counted_fifo_pkg::*;
#(
    parameter int DATA_SIZE_END      = DEFAULT_DATA_SIZE_END,
    parameter int DEPTH_BITS         = DEFAULT_DEPTH_BITS,
    parameter int ALMOST_FULL_LEVEL  = (2**DEPTH_BITS)-1,
    parameter int ALMOST_EMPTY_LEVEL = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   insertValue,
    input  logic                   popValue,
    input  logic [DATA_SIZE_END:0] inValue,
    output logic [DATA_SIZE_END:0] outValue,
    output logic                   empty,
    output logic                   full,
    output logic [DEPTH_BITS:0]    count,
    output logic                   almostFull,
    output logic                   almostEmpty,
    output logic                   overflow,
    output logic                   underflow
);

    localparam logic [DEPTH_BITS:0] FULL_CNT = (DEPTH_BITS+1)'(2**DEPTH_BITS);
    localparam logic [DEPTH_BITS:0] AF_LVL   = (DEPTH_BITS+1)'(ALMOST_FULL_LEVEL);
    localparam logic [DEPTH_BITS:0] AE_LVL   = (DEPTH_BITS+1)'(ALMOST_EMPTY_LEVEL);

    logic [DEPTH_BITS-1:0]  rd_ptr;
    logic [DEPTH_BITS-1:0]  wr_ptr;
    logic [DATA_SIZE_END:0] head;
    logic                   do_push;
    logic                   do_pop;
    fifo_op_e               op;

    // Status comes from count, so full and empty stay distinct when the pointers meet.
    assign empty       = (count == '0);
    assign full        = (count == FULL_CNT);
    assign almostFull  = (count >= AF_LVL);
    assign almostEmpty = (count <= AE_LVL);

    // When full, a simultaneous pop frees the slot the insert lands in.
    assign do_push = insertValue && (!full || popValue);
    assign do_pop  = popValue && !empty;
    assign op      = fifo_op_e'({do_push, do_pop});

    fifo_storage #(
        .DATA_SIZE_END (DATA_SIZE_END),
        .DEPTH_BITS    (DEPTH_BITS)
    ) u_storage (
        .clk   (clk),
        .we    (do_push && !flush),
        .waddr (wr_ptr),
        .wdata (inValue),
        .raddr (rd_ptr),
        .rdata (head)
    );

    assign outValue = empty ? '0 : head;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case (op)
                OP_PUSH: count <= count + 1'b1;
                OP_POP:  count <= count - 1'b1;
                default: count <= count;
            endcase
            if (insertValue && !do_push) begin
                overflow <= 1'b1;
            end
            if (popValue && !do_pop) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_counted_fifo.sv
// Directed self-checking bench for counted_fifo with DEPTH_BITS=3 and default levels.
module tb_counted_fifo;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        insertValue;
    logic        popValue;
    logic [63:0] inValue;
    logic [63:0] outValue;
    logic        empty;
    logic        full;
    logic [3:0]  count;
    logic        almostFull;
    logic        almostEmpty;
    logic        overflow;
    logic        underflow;

    int total = 0;
    int bad   = 0;

    counted_fifo #(
        .DATA_SIZE_END (63),
        .DEPTH_BITS    (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .insertValue (insertValue),
        .popValue    (popValue),
        .inValue     (inValue),
        .outValue    (outValue),
        .empty       (empty),
        .full        (full),
        .count       (count),
        .almostFull  (almostFull),
        .almostEmpty (almostEmpty),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush       = 1'b0;
        insertValue = 1'b0;
        popValue    = 1'b0;
        inValue     = '0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_out"},   outValue,    64'd0);
        chk({tag, "_count"}, 64'(count),  64'd0);
        chk({tag, "_empty"}, 64'(empty),  64'd1);
        chk({tag, "_full"},  64'(full),   64'd0);
        chk({tag, "_ae"},    64'(almostEmpty), 64'd1);
        chk({tag, "_af"},    64'(almostFull),  64'd0);
        chk({tag, "_ovf"},   64'(overflow),    64'd0);
        chk({tag, "_unf"},   64'(underflow),   64'd0);
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        chk_reset_state("rst");
        reset = 1'b0;
        tick();
        chk_reset_state("post_rst");

        // Fill with 1..8
        for (int i = 1; i <= 8; i++) begin
            insertValue = 1'b1;
            inValue     = 64'(i);
            tick();
            chk("fill_count", 64'(count), 64'(i));
            chk("fill_af",    64'(almostFull),  (i >= 7) ? 64'd1 : 64'd0);
            chk("fill_ae",    64'(almostEmpty), (i <= 1) ? 64'd1 : 64'd0);
            chk("fill_full",  64'(full),        (i == 8) ? 64'd1 : 64'd0);
            chk("fill_head",  outValue, 64'd1);
            chk("fill_ovf",   64'(overflow), 64'd0);
        end

        // Overflow while full
        inValue = 64'd9;
        tick();
        chk("ovf_count", 64'(count), 64'd8);
        chk("ovf_flag",  64'(overflow), 64'd1);
        chk("ovf_head",  outValue, 64'd1);
        insertValue = 1'b0;

        // Drain, head visible before each pop
        for (int i = 1; i <= 8; i++) begin
            chk("drain_head", outValue, 64'(i));
            popValue = 1'b1;
            tick();
        end
        popValue = 1'b0;
        chk("drain_empty", 64'(empty), 64'd1);
        chk("drain_out",   outValue, 64'd0);
        chk("drain_count", 64'(count), 64'd0);
        chk("drain_ovf_sticky", 64'(overflow), 64'd1);
        chk("drain_unf",   64'(underflow), 64'd0);

        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush1_ovf", 64'(overflow), 64'd0);

        // Refill with 100..107 then push+pop across the pointer wrap
        for (int i = 0; i < 8; i++) begin
            insertValue = 1'b1;
            inValue     = 64'(100 + i);
            tick();
        end
        chk("refill_full", 64'(full), 64'd1);
        popValue = 1'b1;
        for (int j = 0; j < 20; j++) begin
            inValue = 64'(108 + j);
            chk("wrap_head", outValue, 64'(100 + j));
            tick();
            chk("wrap_count", 64'(count), 64'd8);
        end
        idle_inputs();
        chk("wrap_head_end", outValue, 64'd120);
        chk("wrap_ovf", 64'(overflow),  64'd0);
        chk("wrap_unf", 64'(underflow), 64'd0);

        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush2_empty", 64'(empty), 64'd1);

        // Insert and pop together while empty
        insertValue = 1'b1;
        popValue    = 1'b1;
        inValue     = 64'hA5A5_0000_1234_5678;
        tick();
        idle_inputs();
        chk("ep_count", 64'(count), 64'd1);
        chk("ep_head",  outValue, 64'hA5A5_0000_1234_5678);
        chk("ep_unf",   64'(underflow), 64'd1);
        chk("ep_ovf",   64'(overflow),  64'd0);

        // Reach count=5 with overflow set
        for (int i = 0; i < 8; i++) begin
            insertValue = 1'b1;
            inValue     = 64'(200 + i);
            tick();
        end
        insertValue = 1'b0;
        chk("pre_fl_count", 64'(count), 64'd8);
        chk("pre_fl_ovf",   64'(overflow), 64'd1);
        popValue = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        popValue = 1'b0;
        chk("pre_fl_count5", 64'(count), 64'd5);
        chk("pre_fl_head",   outValue, 64'd202);

        // Flush beats a simultaneous insert+pop
        flush       = 1'b1;
        insertValue = 1'b1;
        popValue    = 1'b1;
        inValue     = 64'd77;
        tick();
        idle_inputs();
        chk("fl_count", 64'(count), 64'd0);
        chk("fl_empty", 64'(empty), 64'd1);
        chk("fl_ovf",   64'(overflow),  64'd0);
        chk("fl_unf",   64'(underflow), 64'd0);
        chk("fl_out",   outValue, 64'd0);

        // Mid-cycle asynchronous reset with count=3
        for (int i = 0; i < 3; i++) begin
            insertValue = 1'b1;
            inValue     = 64'(30 + i);
            tick();
        end
        insertValue = 1'b0;
        chk("ar_pre_count", 64'(count), 64'd3);
        #2;
        reset = 1'b1;
        #1;
        chk_reset_state("ar");
        #1;
        reset = 1'b0;
        insertValue = 1'b1;
        inValue     = 64'h55;
        tick();
        idle_inputs();
        chk("ar_ins_head",  outValue, 64'h55);
        chk("ar_ins_count", 64'(count), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
